pcie_intx_responder: RTL and testbench

PCIE_INTX_RESPONDER -- requirements
Module: pcie_intx_responder

---
 rtl/pcie_intx_responder.sv | 138 +++++++++++++
 tb/tb_pcie_intx_responder.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_intx_responder.sv
// PCIe legacy INTx responder: converts IRQ_REQ level edges into Assert/Deassert_INTA messages and a delayed IRQ_ACK pulse.
// Define PCIE_INTX_STATS_EN to build the saturating Assert/Deassert message counters; otherwise they read as 0.

module pcie_intx_responder #(
    parameter int ACK_DELAY = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        IRQ_REQ,
    output logic        IRQ_ACK,
    input  logic        INTX_DISABLE,
    output logic        MSG_VALID,
    output logic        MSG_TYPE,
    input  logic        MSG_READY,
    output logic        INTA_WIRE,
    output logic        PROTO_ERR,
    output logic [15:0] ASSERT_COUNT,
    output logic [15:0] DEASSERT_COUNT
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, ACK} state_t;

    localparam logic [7:0] DELAY = 8'(ACK_DELAY);

    state_t     state;
    logic       req_state;
    logic       req_latched;
    logic       ack_pending;
    logic       irq_req_q;
    logic [7:0] wait_cnt;

    logic new_target;
    logic cur_target;
    logic handshake;

    assign new_target = IRQ_REQ & ~INTX_DISABLE;
    assign cur_target = req_state & ~INTX_DISABLE;
    assign handshake  = MSG_VALID & MSG_READY;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            req_state   <= 1'b0;
            req_latched <= 1'b0;
            ack_pending <= 1'b0;
            irq_req_q   <= 1'b0;
            wait_cnt    <= '0;
            IRQ_ACK     <= 1'b0;
            MSG_VALID   <= 1'b0;
            MSG_TYPE    <= 1'b0;
            INTA_WIRE   <= 1'b0;
            PROTO_ERR   <= 1'b0;
        end else begin
            irq_req_q <= IRQ_REQ;
            // NOTE: IRQ_ACK is cleared by default every cycle, so only the WAIT/SEND/IDLE exits into ACK can raise it, and only for one cycle.
            IRQ_ACK   <= 1'b0;

            // Any edge on IRQ_REQ while busy is a protocol violation; the level is re-evaluated back in IDLE.
            if (state != IDLE && IRQ_REQ != irq_req_q)
                PROTO_ERR <= 1'b1;

            case (state)
                IDLE: begin
                    if (IRQ_REQ != req_state) begin
                        req_latched <= IRQ_REQ;
                        ack_pending <= 1'b1;
                        if (new_target != INTA_WIRE) begin
                            state     <= SEND;
                            MSG_VALID <= 1'b1;
                            MSG_TYPE  <= ~new_target;
                        end else if (DELAY == 8'd0) begin
                            state   <= ACK;
                            IRQ_ACK <= 1'b1;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= DELAY;
                        end
                    end else if (cur_target != INTA_WIRE) begin
                        ack_pending <= 1'b0;
                        state       <= SEND;
                        MSG_VALID   <= 1'b1;
                        MSG_TYPE    <= ~cur_target;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        MSG_VALID <= 1'b0;
                        INTA_WIRE <= ~INTA_WIRE;
                        if (!ack_pending) begin
                            state <= IDLE;
                        end else if (DELAY == 8'd0) begin
                            state   <= ACK;
                            IRQ_ACK <= 1'b1;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= DELAY;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt <= 8'd1) begin
                        state   <= ACK;
                        IRQ_ACK <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                ACK: begin
                    req_state   <= req_latched;
                    ack_pending <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PCIE_INTX_STATS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ASSERT_COUNT   <= '0;
            DEASSERT_COUNT <= '0;
        end else if (handshake) begin
            if (!MSG_TYPE) begin
                if (ASSERT_COUNT != 16'hFFFF)
                    ASSERT_COUNT <= ASSERT_COUNT + 16'd1;
            end else begin
                if (DEASSERT_COUNT != 16'hFFFF)
                    DEASSERT_COUNT <= DEASSERT_COUNT + 16'd1;
            end
        end
    end
`else
    assign ASSERT_COUNT   = '0;
    assign DEASSERT_COUNT = '0;
`endif

endmodule

// File: tb/tb_pcie_intx_responder.sv
// Bench for pcie_intx_responder: ACK_DELAY=4 and ACK_DELAY=0 instances share stimulus and are checked
// against an event-schedule reference model (when is the link busy, when is the ack due).
`timescale 1ns/1ps

module tb_pcie_intx_responder;

    localparam int NDUT = 2;

    logic clk = 1'b0;
    logic resetn, irq_req, intx_dis, msg_ready;
    logic        ack   [NDUT];
    logic        valid [NDUT];
    logic        mtype [NDUT];
    logic        inta  [NDUT];
    logic        perr  [NDUT];
    logic [15:0] acnt  [NDUT];
    logic [15:0] dcnt  [NDUT];

    int cyc, n_checks, n_fail, stats_exp;

    // Reference model: acknowledged level, pending level, link offer, ack due time, busy horizon.
    int m_lvl [NDUT], m_pend [NDUT], m_inta [NDUT], m_perr [NDUT], m_prev [NDUT];
    int m_idle_from [NDUT], m_offer [NDUT], m_type [NDUT], m_with_ack [NDUT];
    int m_ack_at [NDUT], m_ac [NDUT], m_dc [NDUT];

    always #5 clk = ~clk;

    pcie_intx_responder #(.ACK_DELAY(4)) dut_d4 (
        .clk(clk), .resetn(resetn), .IRQ_REQ(irq_req), .IRQ_ACK(ack[0]),
        .INTX_DISABLE(intx_dis), .MSG_VALID(valid[0]), .MSG_TYPE(mtype[0]),
        .MSG_READY(msg_ready), .INTA_WIRE(inta[0]), .PROTO_ERR(perr[0]),
        .ASSERT_COUNT(acnt[0]), .DEASSERT_COUNT(dcnt[0])
    );

    pcie_intx_responder #(.ACK_DELAY(0)) dut_d0 (
        .clk(clk), .resetn(resetn), .IRQ_REQ(irq_req), .IRQ_ACK(ack[1]),
        .INTX_DISABLE(intx_dis), .MSG_VALID(valid[1]), .MSG_TYPE(mtype[1]),
        .MSG_READY(msg_ready), .INTA_WIRE(inta[1]), .PROTO_ERR(perr[1]),
        .ASSERT_COUNT(acnt[1]), .DEASSERT_COUNT(dcnt[1])
    );

    function automatic int dly(int i);
        return (i == 0) ? 4 : 0;
    endfunction

    function automatic void model_reset(int i, int t);
        m_lvl[i] = 0; m_pend[i] = 0; m_inta[i] = 0; m_perr[i] = 0; m_prev[i] = 0;
        m_offer[i] = 0; m_type[i] = 0; m_with_ack[i] = 0; m_ack_at[i] = -1;
        m_ac[i] = 0; m_dc[i] = 0; m_idle_from[i] = t + 1;
    endfunction

    // Advance the model by one rising edge t using the inputs sampled at that edge.
    function automatic void model_step(int i, int t);
        int tgt;
        bit busy;
        if (!resetn) begin
            model_reset(i, t);
            return;
        end
        busy = (m_offer[i] != 0) || (t < m_idle_from[i]);
        if (busy && int'(irq_req) != m_prev[i])
            m_perr[i] = 1;
        if (t == m_ack_at[i] + 1)
            m_lvl[i] = m_pend[i];
        if (m_offer[i] != 0) begin
            if (msg_ready) begin
                m_offer[i] = 0;
                m_inta[i]  = 1 - m_inta[i];
                if (m_type[i] == 0) m_ac[i] = (m_ac[i] < 65535) ? m_ac[i] + 1 : 65535;
                else                m_dc[i] = (m_dc[i] < 65535) ? m_dc[i] + 1 : 65535;
                if (m_with_ack[i] != 0) begin
                    m_ack_at[i]    = t + dly(i);
                    m_idle_from[i] = t + dly(i) + 2;
                end else begin
                    m_idle_from[i] = t + 1;
                end
            end
        end else if (t >= m_idle_from[i]) begin
            if (int'(irq_req) != m_lvl[i]) begin
                m_pend[i] = int'(irq_req);
                tgt = (irq_req && !intx_dis) ? 1 : 0;
                if (tgt != m_inta[i]) begin
                    m_offer[i] = 1; m_type[i] = 1 - tgt; m_with_ack[i] = 1;
                end else begin
                    m_ack_at[i]    = t + dly(i);
                    m_idle_from[i] = t + dly(i) + 2;
                end
            end else begin
                tgt = (m_lvl[i] != 0 && !intx_dis) ? 1 : 0;
                if (tgt != m_inta[i]) begin
                    m_offer[i] = 1; m_type[i] = 1 - tgt; m_with_ack[i] = 0;
                end
            end
        end
        m_prev[i] = int'(irq_req);
    endfunction

    function automatic logic [36:0] exp_vec(int i);
        logic [15:0] ea, ed;
`ifdef PCIE_INTX_STATS_EN
        ea = 16'(m_ac[i]);
        ed = 16'(m_dc[i]);
`else
        ea = '0;
        ed = '0;
`endif
        return {m_offer[i] != 0, m_type[i] != 0, m_ack_at[i] == cyc, m_inta[i] != 0, m_perr[i] != 0, ea, ed};
    endfunction

    function automatic logic [36:0] got_vec(int i);
        return {valid[i], mtype[i], ack[i], inta[i], perr[i], acnt[i], dcnt[i]};
    endfunction

    // One rising edge; the model follows it, and outputs are then sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        cyc++;
        for (int i = 0; i < NDUT; i++) model_step(i, cyc);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; irq_req = 1'b0; intx_dis = 1'b0; msg_ready = 1'b1;
        repeat (3) begin
            tick();
            for (int i = 0; i < NDUT; i++) begin
                n_checks++;
                if (got_vec(i) !== 37'd0) begin
                    n_fail++;
                    $display("FAIL reset dut%0d cyc %0d got %h exp 0", i, cyc, got_vec(i));
                end
            end
        end
        resetn = 1'b1;
        repeat (2) begin
            tick();
            for (int i = 0; i < NDUT; i++) begin
                n_checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL reset_release dut%0d cyc %0d got %h exp %h", i, cyc, got_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_assert_latency();
        int n0;
        int ack_n [NDUT], ack_c [NDUT], val_c [NDUT];
        for (int i = 0; i < NDUT; i++) begin ack_n[i] = 0; ack_c[i] = -1; val_c[i] = -1; end
        irq_req = 1'b1;
        n0 = cyc + 1;
        repeat (12) begin
            tick();
            for (int i = 0; i < NDUT; i++) begin
                n_checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL latency dut%0d cyc %0d got %h exp %h", i, cyc, got_vec(i), exp_vec(i));
                end
                if (ack[i] === 1'b1) begin ack_n[i]++; ack_c[i] = cyc; end
                if (valid[i] === 1'b1 && val_c[i] < 0) val_c[i] = cyc;
            end
        end
        for (int i = 0; i < NDUT; i++) begin
            n_checks++;
            if (ack_n[i] != 1 || ack_c[i] != n0 + 1 + dly(i) || val_c[i] != n0 || inta[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL latency_timing dut%0d acks %0d at %0d valid at %0d inta %b, exp 1 ack at %0d valid at %0d inta 1",
                         i, ack_n[i], ack_c[i], val_c[i], inta[i], n0 + 1 + dly(i), n0);
            end
        end
    endtask

    task automatic test_backpressure();
        int h;
        int ack_n [NDUT], ack_c [NDUT];
        for (int i = 0; i < NDUT; i++) begin ack_n[i] = 0; ack_c[i] = -1; end
        msg_ready = 1'b0;
        irq_req   = 1'b0;
        repeat (20) begin
            tick();
            for (int i = 0; i < NDUT; i++) begin
                n_checks++;
                if (got_vec(i) !== exp_vec(i) || valid[i] !== 1'b1 || mtype[i] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL backpressure_hold dut%0d cyc %0d got %h exp %h", i, cyc, got_vec(i), exp_vec(i));
                end
            end
        end
        msg_ready = 1'b1;
        h = cyc + 1;
        repeat (10) begin
            tick();
            for (int i = 0; i < NDUT; i++) begin
                n_checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL backpressure dut%0d cyc %0d got %h exp %h", i, cyc, got_vec(i), exp_vec(i));
                end
                if (ack[i] === 1'b1) begin ack_n[i]++; ack_c[i] = cyc; end
            end
        end
        for (int i = 0; i < NDUT; i++) begin
            n_checks++;
            if (ack_n[i] != 1 || ack_c[i] != h + dly(i) || inta[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_ack dut%0d acks %0d at %0d inta %b, exp 1 at %0d inta 0",
                         i, ack_n[i], ack_c[i], inta[i], h + dly(i));
            end
        end
    endtask

    task automatic test_disable();
        // {INTX_DISABLE, IRQ_REQ, message expected, acks expected} per phase
        logic [3:0] phases [4] = '{4'b1_1_0_1, 4'b0_1_1_0, 4'b1_1_1_0, 4'b1_0_0_1};
        int ack_n, val_n;
        for (int p = 0; p < 4; p++) begin
            intx_dis = phases[p][3];
            irq_req  = phases[p][2];
            for (int i = 0; i < NDUT; i++) begin
                ack_n = 0; val_n = 0;
                if (i == 1) begin
                    intx_dis = phases[p][3];
                end
            end
            begin
                int acks [NDUT], vals [NDUT];
                for (int i = 0; i < NDUT; i++) begin acks[i] = 0; vals[i] = 0; end
                repeat (10) begin
                    tick();
                    for (int i = 0; i < NDUT; i++) begin
                        n_checks++;
                        if (got_vec(i) !== exp_vec(i)) begin
                            n_fail++;
                            $display("FAIL disable_p%0d dut%0d cyc %0d got %h exp %h", p, i, cyc, got_vec(i), exp_vec(i));
                        end
                        if (ack[i] === 1'b1) acks[i]++;
                        if (valid[i] === 1'b1) vals[i]++;
                    end
                end
                for (int i = 0; i < NDUT; i++) begin
                    n_checks++;
                    if ((vals[i] != 0) != phases[p][1] || acks[i] != int'(phases[p][0])) begin
                        n_fail++;
                        $display("FAIL disable_summary_p%0d dut%0d msg cycles %0d acks %0d, exp msg %0d acks %0d",
                                 p, i, vals[i], acks[i], phases[p][1], phases[p][0]);
                    end
                end
            end
        end
        intx_dis = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_proto_err();
        int acks [NDUT];
        for (int i = 0; i < NDUT; i++) acks[i] = 0;
        irq_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 1) irq_req = 1'b0;
            for (int i = 0; i < NDUT; i++) begin
                n_checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL proto_err dut%0d cyc %0d got %h exp %h", i, cyc, got_vec(i), exp_vec(i));
                end
                if (ack[i] === 1'b1) acks[i]++;
            end
        end
        for (int i = 0; i < NDUT; i++) begin
            n_checks++;
            if (perr[i] !== 1'b1 || acks[i] != 2 || inta[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL proto_err_summary dut%0d perr %b acks %0d inta %b, exp perr 1 acks 2 inta 0",
                         i, perr[i], acks[i], inta[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int acks [NDUT];
        irq_req = 1'b1;
        repeat (3) begin
            tick();
            for (int i = 0; i < NDUT; i++) begin
                n_checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL abort_pre dut%0d cyc %0d got %h exp %h", i, cyc, got_vec(i), exp_vec(i));
                end
            end
        end
        resetn = 1'b0;
        repeat (2) begin
            tick();
            for (int i = 0; i < NDUT; i++) begin
                n_checks++;
                if (got_vec(i) !== 37'd0) begin
                    n_fail++;
                    $display("FAIL abort_reset dut%0d cyc %0d got %h exp 0", i, cyc, got_vec(i));
                end
            end
        end
        resetn = 1'b1;
        for (int i = 0; i < NDUT; i++) acks[i] = 0;
        repeat (12) begin
            tick();
            for (int i = 0; i < NDUT; i++) begin
                n_checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL abort_post dut%0d cyc %0d got %h exp %h", i, cyc, got_vec(i), exp_vec(i));
                end
                if (ack[i] === 1'b1) acks[i]++;
            end
        end
        for (int i = 0; i < NDUT; i++) begin
            n_checks++;
            if (acks[i] != 1 || inta[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL abort_fresh_request dut%0d acks %0d inta %b, exp acks 1 inta 1", i, acks[i], inta[i]);
            end
        end
    endtask

    task automatic test_stats();
        resetn = 1'b0; irq_req = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        for (int r = 0; r < 6; r++) begin
            irq_req = (r % 2 == 0);
            repeat (12) begin
                tick();
                for (int i = 0; i < NDUT; i++) begin
                    n_checks++;
                    if (got_vec(i) !== exp_vec(i)) begin
                        n_fail++;
                        $display("FAIL stats dut%0d cyc %0d got %h exp %h", i, cyc, got_vec(i), exp_vec(i));
                    end
                end
            end
        end
        for (int i = 0; i < NDUT; i++) begin
            n_checks++;
            if (acnt[i] !== 16'(stats_exp) || dcnt[i] !== 16'(stats_exp)) begin
                n_fail++;
                $display("FAIL stats_totals dut%0d assert %0d deassert %0d, exp %0d/%0d",
                         i, acnt[i], dcnt[i], stats_exp, stats_exp);
            end
        end
    endtask

    task automatic test_random();
        repeat (3000) begin
            resetn    = ($urandom_range(0, 299) != 0);
            msg_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0)  irq_req  = ~irq_req;
            if ($urandom_range(0, 24) == 0) intx_dis = ~intx_dis;
            tick();
            for (int i = 0; i < NDUT; i++) begin
                n_checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc %0d got %h exp %h", i, cyc, got_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    initial begin
        resetn = 1'b0; irq_req = 1'b0; intx_dis = 1'b0; msg_ready = 1'b1;
        cyc = 0; n_checks = 0; n_fail = 0;
`ifdef PCIE_INTX_STATS_EN
        stats_exp = 3;
`else
        stats_exp = 0;
`endif
        for (int i = 0; i < NDUT; i++) model_reset(i, 0);

        test_reset();
        test_assert_latency();
        test_backpressure();
        test_disable();
        test_proto_err();
        test_reset_abort();
        test_stats();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
